// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// ID/EX issue stage in front of the 4-bit-coded ALU. It decodes an RV32I
// instruction into an ALU control code, resolves EX/MEM and MEM/WB forwarding
// for rs1/rs2, selects the operands (register, immediate or PC) and registers
// the result in a valid/ready pipeline register that drives the ALU directly.
//
// Ports:
//   clk, rst            pipeline clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (instr, pc, rs1_data, rs2_data)
//   fwd_exmem_*         EX/MEM forwarding source (en, rd, data)
//   fwd_memwb_*         MEM/WB forwarding source (en, rd, data)
//   flush               kill the held and any incoming instruction
//   out_valid/out_ready downstream handshake
//   alu_a, alu_b        ALU operands
//   alu_control         0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 AND, 5 OR, 6 XOR,
//                       7 SRL, 8 SRA, 9 SLTU, 10 pass-B
//   out_rd, out_wen     writeback destination and enable
//   out_illegal         undecodable instruction
//
// Build option: define SKID_BUF_EN to add a skid entry. in_ready then comes
// straight from a flop (skid entry empty) and has no combinational path from
// out_ready, while full throughput is kept. Without it the stage is a single
// register and in_ready = !out_valid || out_ready.
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int unsigned     XLEN             = 32,
  parameter logic [XLEN-1:0] RESET_PC_OPERAND = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            fwd_exmem_en,
  input  logic [4:0]      fwd_exmem_rd,
  input  logic [XLEN-1:0] fwd_exmem_data,
  input  logic            fwd_memwb_en,
  input  logic [4:0]      fwd_memwb_rd,
  input  logic [XLEN-1:0] fwd_memwb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;

  // Everything the ALU stage needs for one instruction.
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_ctrl_e       ctrl;
    logic [4:0]      rd;
    logic            wen;
    logic            illegal;
  } issue_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam issue_t RESET_ISSUE = '{
    a: RESET_PC_OPERAND, b: RESET_PC_OPERAND, ctrl: ALU_ADD,
    rd: 5'd0, wen: 1'b0, illegal: 1'b0
  };

  // ---------------------------------------------------------------------------
  // Field extraction and immediates
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] i_imm, s_imm, u_imm, shamt_imm;

  assign opcode  = instr[6:0];
  assign rd_idx  = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign funct7  = instr[31:25];

  assign i_imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign s_imm     = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign u_imm     = XLEN'({instr[31:12], 12'b0});
  assign shamt_imm = {{(XLEN-5){1'b0}}, instr[24:20]};

  // ---------------------------------------------------------------------------
  // Forwarding: x0 is hard zero, then youngest producer (EX/MEM) wins.
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf,
    input logic            ex_en,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            wb_en,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (rs == 5'd0)                   return '0;
    else if (ex_en && (ex_rd == rs))  return ex_data;
    else if (wb_en && (wb_rd == rs))  return wb_data;
    else                              return rf;
  endfunction

  logic [XLEN-1:0] rs1_fwd, rs2_fwd, rs2_shamt;

  assign rs1_fwd = fwd_sel(rs1_idx, rs1_data, fwd_exmem_en, fwd_exmem_rd, fwd_exmem_data,
                           fwd_memwb_en, fwd_memwb_rd, fwd_memwb_data);
  assign rs2_fwd = fwd_sel(rs2_idx, rs2_data, fwd_exmem_en, fwd_exmem_rd, fwd_exmem_data,
                           fwd_memwb_en, fwd_memwb_rd, fwd_memwb_data);

  // The ALU shifts by all of B, so register shifts must be trimmed to 5 bits.
  assign rs2_shamt = {{(XLEN-5){1'b0}}, rs2_fwd[4:0]};

  function automatic alu_ctrl_e f3_ctrl(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  issue_t issue_d;
  logic   is_shift;

  assign is_shift = (funct3[1:0] == 2'b01);  // SLL(I) / SRL(I) / SRA(I)

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path through the case can infer a latch.
    issue_d = '0;
    case (opcode)
      OPC_OP: begin
        issue_d.a    = rs1_fwd;
        issue_d.b    = is_shift ? rs2_shamt : rs2_fwd;
        issue_d.ctrl = f3_ctrl(funct3, funct7 == F7_ALT);
        issue_d.wen  = 1'b1;
        // Alternate funct7 only exists for SUB and SRA.
        if (!((funct7 == F7_BASE) ||
              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
          issue_d.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        issue_d.a    = rs1_fwd;
        issue_d.b    = is_shift ? shamt_imm : i_imm;
        issue_d.ctrl = f3_ctrl(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        issue_d.wen  = 1'b1;
        if ((funct3 == 3'b001) && (funct7 != F7_BASE))
          issue_d.illegal = 1'b1;
        if ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT))
          issue_d.illegal = 1'b1;
      end
      OPC_LUI: begin
        issue_d.b    = u_imm;
        issue_d.ctrl = ALU_PASSB;
        issue_d.wen  = 1'b1;
      end
      OPC_AUIPC: begin
        issue_d.a   = pc;
        issue_d.b   = u_imm;
        issue_d.wen = 1'b1;
      end
      OPC_LOAD: begin
        issue_d.a   = rs1_fwd;
        issue_d.b   = i_imm;
        issue_d.wen = 1'b1;
      end
      OPC_STORE: begin
        issue_d.a = rs1_fwd;
        issue_d.b = s_imm;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU produces the link value; the target is computed elsewhere.
        issue_d.a   = pc;
        issue_d.b   = XLEN'(4);
        issue_d.wen = 1'b1;
      end
      default: issue_d.illegal = 1'b1;
    endcase

    // Any illegal encoding issues as an inert ADD 0,0 with no writeback.
    if (issue_d.illegal) begin
      issue_d         = '0;
      issue_d.illegal = 1'b1;
    end

    // A write to x0 is no write at all.
    if (issue_d.wen && (rd_idx != 5'd0)) begin
      issue_d.rd = rd_idx;
    end else begin
      issue_d.wen = 1'b0;
      issue_d.rd  = 5'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline register(s)
  // ---------------------------------------------------------------------------
  issue_t out_q;
  logic   out_valid_q;
  logic   accept;

  assign accept = in_valid && in_ready;

`ifdef SKID_BUF_EN
  issue_t skid_q;
  logic   skid_valid_q;

  // Registered ready: upstream may send whenever the skid entry is free.
  assign in_ready = !skid_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= RESET_ISSUE;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot frees up: the older skid entry goes first.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= issue_d;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
    end
  end

  // NOTE: the skid payload is pure data qualified by skid_valid_q, so it has
  // no reset; only the valid flag must come up clean.
  always_ff @(posedge clk) begin
    if (accept) skid_q <= issue_d;
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= RESET_ISSUE;
    end else begin
      // Flush wins over a same-cycle accept; the data may go stale.
      if (flush)          out_valid_q <= 1'b0;
      else if (accept)    out_valid_q <= 1'b1;
      else if (out_ready) out_valid_q <= 1'b0;
      if (accept) out_q <= issue_d;
    end
  end
`endif

  assign out_valid   = out_valid_q;
  assign alu_a       = out_q.a;
  assign alu_b       = out_q.b;
  assign alu_control = out_q.ctrl;
  assign out_rd      = out_q.rd;
  assign out_wen     = out_q.wen;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Table of hand-encoded RV32I instructions with hand-derived expected ALU
// operands. Accepted instructions are pushed to a scoreboard queue and popped
// when the stage presents them. Hand sequences cover backpressure, flush and
// asynchronous reset. Exercises the default (single register) build.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam logic [31:0] RST_OP = 32'hC0DE_0000;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic        fwd_exmem_en, fwd_memwb_en;
  logic [4:0]  fwd_exmem_rd, fwd_memwb_rd;
  logic [31:0] fwd_exmem_data, fwd_memwb_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [4:0]  out_rd;
  logic        out_wen, out_illegal;

  alu_issue_stage #(.XLEN(32), .RESET_PC_OPERAND(RST_OP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_exmem_en(fwd_exmem_en), .fwd_exmem_rd(fwd_exmem_rd), .fwd_exmem_data(fwd_exmem_data),
    .fwd_memwb_en(fwd_memwb_en), .fwd_memwb_rd(fwd_memwb_rd), .fwd_memwb_data(fwd_memwb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .out_rd(out_rd), .out_wen(out_wen), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr, pc, rs1, rs2;
    logic        exen;
    logic [4:0]  exrd;
    logic [31:0] exdata;
    logic        wben;
    logic [4:0]  wbrd;
    logic [31:0] wbdata;
    logic [31:0] a, b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        wen, ill;
    logic        chk;     // compare a/b/control (not defined for every illegal)
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];
  vec_t sb[$];
  vec_t cur;
  bit   acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [31:0] ins, input logic [31:0] p,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [3:0] c, input logic [4:0] d,
                              input logic w, input logic il, input logic ck);
    vec_t v;
    v.name = n; v.instr = ins; v.pc = p; v.rs1 = r1; v.rs2 = r2;
    v.exen = 1'b0; v.exrd = 5'd0; v.exdata = 32'h0;
    v.wben = 1'b0; v.wbrd = 5'd0; v.wbdata = 32'h0;
    v.a = ea; v.b = eb; v.ctrl = c; v.rd = d; v.wen = w; v.ill = il; v.chk = ck;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    cur = v;
    instr = v.instr; pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2;
    fwd_exmem_en = v.exen; fwd_exmem_rd = v.exrd; fwd_exmem_data = v.exdata;
    fwd_memwb_en = v.wben; fwd_memwb_rd = v.wbrd; fwd_memwb_data = v.wbdata;
  endtask

  task automatic check_out(input vec_t e);
    if (e.chk) begin
      check({e.name, ".alu_a"}, alu_a, e.a);
      check({e.name, ".alu_b"}, alu_b, e.b);
      check({e.name, ".alu_control"}, 32'(alu_control), 32'(e.ctrl));
    end
    check({e.name, ".out_rd"}, 32'(out_rd), 32'(e.rd));
    check({e.name, ".out_wen"}, 32'(out_wen), 32'(e.wen));
    check({e.name, ".out_illegal"}, 32'(out_illegal), 32'(e.ill));
  endtask

  // One cycle: compare any delivered output at negedge, record an accept,
  // then cross the rising edge and return 1 time unit after it.
  task automatic step(output bit accepted);
    vec_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got out_valid=1 control=%0d, required no pending instruction",
                 alu_control);
      end else begin
        e = sb.pop_front();
        check_out(e);
      end
    end
    accepted = in_valid && in_ready && !flush && !rst;
    if (accepted) sb.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) step(a);
    step(a);  // one idle cycle: any extra output is reported as unexpected
    check({name, ".drain_empty"}, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t v, va, vb;
    int   n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    apply(mk("idle", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0));

    // ---- reset values ----
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", 32'(out_valid), 0);
    check("reset.alu_a", alu_a, RST_OP);
    check("reset.alu_b", alu_b, RST_OP);
    check("reset.alu_control", 32'(alu_control), 0);
    check("reset.out_rd", 32'(out_rd), 0);
    check("reset.out_wen", 32'(out_wen), 0);
    check("reset.out_illegal", 32'(out_illegal), 0);
    rst = 1'b0;

    // ---- vector table: name, instr, pc, rs1, rs2, a, b, ctrl, rd, wen, ill, chk ----
    vecs.push_back(mk("add",   32'h002081B3, 32'h100, 32'd5, 32'd7, 32'd5, 32'd7, 4'd0, 5'd3, 1, 0, 1));
    vecs.push_back(mk("sub",   32'h402081B3, 32'h100, 32'd5, 32'd7, 32'd5, 32'd7, 4'd1, 5'd3, 1, 0, 1));
    vecs.push_back(mk("sll",   32'h002091B3, 32'h100, 32'd5, 32'hFFFFFF25, 32'd5, 32'd5, 4'd2, 5'd3, 1, 0, 1));
    vecs.push_back(mk("slt",   32'h0020A1B3, 32'h100, 32'd5, 32'd7, 32'd5, 32'd7, 4'd3, 5'd3, 1, 0, 1));
    vecs.push_back(mk("sltu",  32'h0020B1B3, 32'h100, 32'd5, 32'd7, 32'd5, 32'd7, 4'd9, 5'd3, 1, 0, 1));
    vecs.push_back(mk("xor",   32'h0020C1B3, 32'h100, 32'd5, 32'd7, 32'd5, 32'd7, 4'd6, 5'd3, 1, 0, 1));
    vecs.push_back(mk("srl",   32'h0020D1B3, 32'h100, 32'd5, 32'h24, 32'd5, 32'd4, 4'd7, 5'd3, 1, 0, 1));
    vecs.push_back(mk("sra",   32'h4020D1B3, 32'h100, 32'd5, 32'h24, 32'd5, 32'd4, 4'd8, 5'd3, 1, 0, 1));
    vecs.push_back(mk("or",    32'h0020E1B3, 32'h100, 32'd5, 32'd7, 32'd5, 32'd7, 4'd5, 5'd3, 1, 0, 1));
    vecs.push_back(mk("and",   32'h0020F1B3, 32'h100, 32'd5, 32'd7, 32'd5, 32'd7, 4'd4, 5'd3, 1, 0, 1));
    vecs.push_back(mk("mul_ill", 32'h022081B3, 32'h100, 32'd5, 32'd7, 32'd0, 32'd0, 4'd0, 5'd0, 0, 1, 0));
    vecs.push_back(mk("addi",  32'hFFF08213, 32'h100, 32'd5, 32'd7, 32'd5, 32'hFFFFFFFF, 4'd0, 5'd4, 1, 0, 1));
    vecs.push_back(mk("srai",  32'h40335293, 32'h100, 32'h80000000, 32'd7, 32'h80000000, 32'd3, 4'd8, 5'd5, 1, 0, 1));
    vecs.push_back(mk("srai_f7", 32'h42335293, 32'h100, 32'd5, 32'd7, 32'd0, 32'd0, 4'd0, 5'd0, 0, 1, 0));
    vecs.push_back(mk("slli",  32'h00331293, 32'h100, 32'd9, 32'd7, 32'd9, 32'd3, 4'd2, 5'd5, 1, 0, 1));
    vecs.push_back(mk("slli_f7", 32'h40331293, 32'h100, 32'd9, 32'd7, 32'd0, 32'd0, 4'd0, 5'd0, 0, 1, 0));
    vecs.push_back(mk("lui",   32'h123453B7, 32'h100, 32'd5, 32'd7, 32'd0, 32'h12345000, 4'd10, 5'd7, 1, 0, 1));
    vecs.push_back(mk("auipc", 32'h00001297, 32'h100, 32'd5, 32'd7, 32'h100, 32'h1000, 4'd0, 5'd5, 1, 0, 1));
    vecs.push_back(mk("lw",    32'hFFC0A303, 32'h100, 32'd5, 32'd7, 32'd5, 32'hFFFFFFFC, 4'd0, 5'd6, 1, 0, 1));
    vecs.push_back(mk("sw",    32'h0020A423, 32'h100, 32'd5, 32'd7, 32'd5, 32'd8, 4'd0, 5'd0, 0, 0, 1));
    vecs.push_back(mk("jal",   32'h000000EF, 32'h200, 32'd5, 32'd7, 32'h200, 32'd4, 4'd0, 5'd1, 1, 0, 1));
    vecs.push_back(mk("jalr",  32'h000100E7, 32'h300, 32'd5, 32'd7, 32'h300, 32'd4, 4'd0, 5'd1, 1, 0, 1));
    vecs.push_back(mk("bad_op", 32'h0000007F, 32'h100, 32'd5, 32'd7, 32'd0, 32'd0, 4'd0, 5'd0, 0, 1, 1));
    vecs.push_back(mk("rd_x0", 32'h00208033, 32'h100, 32'd5, 32'd7, 32'd5, 32'd7, 4'd0, 5'd0, 0, 0, 1));
    v = mk("fwd_both", 32'h002081B3, 32'h100, 32'h1111, 32'd7, 32'hAAAA0000, 32'd7, 4'd0, 5'd3, 1, 0, 1);
    v.exen = 1; v.exrd = 5'd1; v.exdata = 32'hAAAA0000;
    v.wben = 1; v.wbrd = 5'd1; v.wbdata = 32'h5555;
    vecs.push_back(v);
    v = mk("fwd_wb", 32'h002081B3, 32'h100, 32'd5, 32'd7, 32'd5, 32'h5555, 4'd0, 5'd3, 1, 0, 1);
    v.exen = 1; v.exrd = 5'd9; v.exdata = 32'hDEAD;
    v.wben = 1; v.wbrd = 5'd2; v.wbdata = 32'h5555;
    vecs.push_back(v);
    v = mk("fwd_ex_off", 32'h002081B3, 32'h100, 32'd5, 32'd7, 32'h5555, 32'd7, 4'd0, 5'd3, 1, 0, 1);
    v.exen = 0; v.exrd = 5'd1; v.exdata = 32'hDEAD;
    v.wben = 1; v.wbrd = 5'd1; v.wbdata = 32'h5555;
    vecs.push_back(v);
    v = mk("fwd_x0", 32'h002001B3, 32'h100, 32'h1234, 32'd7, 32'd0, 32'd7, 4'd0, 5'd3, 1, 0, 1);
    v.exen = 1; v.exrd = 5'd0; v.exdata = 32'hDEAD;
    v.wben = 1; v.wbrd = 5'd0; v.wbdata = 32'hBEEF;
    vecs.push_back(v);

    // ---- phase 1: back-to-back at full throughput ----
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      in_valid = 1'b1;
      step(acc);
      check({vecs[i].name, ".stream_accept"}, 32'(acc), 1);
    end
    drain("stream");

    // ---- phase 2: random valid / ready ----
    foreach (vecs[i]) begin
      apply(vecs[i]);
      n = 0;
      do begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        step(acc);
        n++;
      end while (!acc && n < 50);
      if (!acc) check({vecs[i].name, ".random_accept_timeout"}, 32'(acc), 1);
    end
    drain("random");

    // ---- backpressure: out_ready low for 3 cycles ----
    va = vecs[0];
    vb = vecs[1];
    apply(va);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step(acc);
    check("bp.first_accept", 32'(acc), 1);
    apply(vb);
    for (int k = 0; k < 3; k++) begin
      step(acc);
      check("bp.no_accept", 32'(acc), 0);
      check("bp.in_ready", 32'(in_ready), 0);
      check("bp.out_valid", 32'(out_valid), 1);
      check("bp.alu_a_held", alu_a, va.a);
      check("bp.alu_control_held", 32'(alu_control), 32'(va.ctrl));
    end
    out_ready = 1'b1;
    step(acc);                // delivers va, accepts vb
    check("bp.release_accept", 32'(acc), 1);
    in_valid = 1'b0;
    step(acc);                // vb must appear exactly here
    check("bp.none_lost", sb.size(), 0);
    drain("bp");

    // ---- flush concurrent with accept ----
    apply(vecs[2]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b1;
    step(acc);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_accept.out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;

    // ---- flush of a held instruction ----
    apply(vecs[3]);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step(acc);
    in_valid = 1'b0;
    flush    = 1'b1;
    step(acc);
    flush = 1'b0;
    if (sb.size() != 0) void'(sb.pop_back());  // killed by the flush
    check("flush_held.out_valid", 32'(out_valid), 0);
    drain("flush");

    // ---- asynchronous reset mid-stream ----
    apply(vecs[4]);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step(acc);
    check("arst.pre_out_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.out_valid", 32'(out_valid), 0);
    check("arst.alu_a", alu_a, RST_OP);
    check("arst.out_wen", 32'(out_wen), 0);
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(vecs[0]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step(acc);
    check("arst.resume_accept", 32'(acc), 1);
    drain("arst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX stage that sits directly upstream of the 4-bit-coded ALU. It decodes a 32-bit RV32I instruction into the ALU control code and selects operands (register, immediate, PC). It resolves EX/MEM and MEM/WB forwarding and registers the result into a one-deep valid/ready pipeline register whose outputs drive the ALU inputs directly.

Parameters:
XLEN, 32, datapath width (only 32 supported)
RESET_PC_OPERAND, 0, value driven on alu_a/alu_b at reset

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
instr  input  32  instruction word
pc  input  32  instruction address
rs1_data  input  32  register file read port 1
rs2_data  input  32  register file read port 2
fwd_exmem_en  input  1  EX/MEM writes a register
fwd_exmem_rd  input  5  EX/MEM destination
fwd_exmem_data  input  32  EX/MEM result
fwd_memwb_en  input  1  MEM/WB writes a register
fwd_memwb_rd  input  5  MEM/WB destination
fwd_memwb_data  input  32  MEM/WB result
flush  input  1  kill held and incoming instruction
out_valid  output  1  registered operands valid
out_ready  input  1  downstream accepts
alu_a  output  32  ALU operand A
alu_b  output  32  ALU operand B
alu_control  output  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 AND, 5 OR, 6 XOR, 7 SRL, 8 SRA, 9 SLTU, 10 pass-B
out_rd  output  5  destination register
out_wen  output  1  writeback enable
out_illegal  output  1  undecodable instruction

Behaviour:
- Reset (async, rst=1):
  - out_valid, out_wen, out_illegal = 0
  - alu_control = 0; out_rd = 0
  - alu_a, alu_b = RESET_PC_OPERAND
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - Latency: 1 cycle from accept to out_valid.
  - Outputs are held stable while out_valid && !out_ready.
- Flush:
  - Next cycle out_valid = 0; any same-cycle accept is discarded (flush wins).
  - Data registers may keep stale values.
- Forwarding, per source rs1/rs2:
  - Index 0 always yields 0.
  - Otherwise EX/MEM match (en && rd==rs) has priority over MEM/WB match, which has priority over register file data.
- Decode by opcode:
  - OP 0110011: A=fwd rs1, B=fwd rs2. funct3 000 → ADD (SUB if funct7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7=0100000), 110 OR, 111 AND. Any other funct7 is illegal. wen=1.
  - OP-IMM 0010011: B=sign-extended imm[11:0], same funct3 map, no SUB. For shifts, B=zero-extended shamt instr[24:20]; funct7 must be 0000000 (SLLI/SRLI) or 0100000 (SRAI), else illegal.
  - Register shifts: B = {27'b0, rs2[4:0]}, because the ALU shifts by the full B.
  - LUI 0110111: control 10, B={instr[31:12],12'b0}, A=0.
  - AUIPC 0010111: ADD, A=pc, B=U-imm.
  - LOAD 0000011: ADD, A=rs1, B=I-imm.
  - STORE 0100011: ADD, A=rs1, B=S-imm, wen=0, rd=0.
  - JAL 1101111 / JALR 1100111: ADD, A=pc, B=4 (link value).
  - Other opcodes: illegal=1, wen=0, control=0, A=B=0.
- out_rd = instr[11:7] whenever wen=1, else 0. rd=x0 forces wen=0.

Optional Feature:
SKID_BUF_EN
- Defined: adds a second (skid) entry.
  - in_ready is a registered signal = skid entry empty; no combinational out_ready→in_ready path.
  - Full throughput is preserved; the skid entry drains to the output register first.
  - flush clears both entries.
- Undefined: single register; in_ready is combinational as described above.

Test Plan:
- ADD: instr 0x002081B3, rs1_data=5, rs2_data=7 → next cycle out_valid=1, alu_a=5, alu_b=7, alu_control=0, out_rd=3, out_wen=1.
- SRAI: instr 0x40335293 → alu_control=8, alu_b=3, out_rd=5.
- Illegal funct7: SRAI with funct7=0100001 → out_illegal=1, out_wen=0.
- LUI: instr 0x123453B7 → alu_control=10, alu_b=0x12345000, out_rd=7.
- Illegal opcode: instr 0x0000007F → out_illegal=1, out_wen=0.
- Forwarding, both paths match: rs1=x1, EX/MEM=0xAAAA0000, MEM/WB=0x5555 → alu_a=0xAAAA0000.
- Forwarding, x0 source: rs1=x0 with fwd rd=0 en=1 → alu_a=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → outputs frozen, in_ready=0 (macro off); release → next instr appears 1 cycle later, none lost or duplicated.
- Flush: flush=1 concurrent with accept → out_valid=0 next cycle.
- Reset: rst asserted mid-stream → out_valid=0 immediately, without waiting for a clock edge.
